// File: rtl/mc_control_unit.sv
// Multicycle CPU control FSM: walks each instruction through IF/ID/EXE/MEM/WB
// and drives the datapath enables and mux selects from (state, op, zero, halted).
module mc_control_unit (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] op,
    input  logic       zero,
    output logic [2:0] state,
    output logic       halted,
    output logic       PCWre,
    output logic [1:0] PCsrc,
    output logic       IRWre,
    output logic       RegWre,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       ExtSel,
    output logic       DataMemRW,
    output logic       DBDataSrc
);
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    state_t state_q, state_d;
    logic   halted_q, halted_d;

    logic       is_r, is_i, is_ls;
    logic [2:0] alu_op_sel;

    assign is_r  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                   (op == OP_OR)  || (op == OP_SLT);
    assign is_i  = (op == OP_ADDI) || (op == OP_ORI);
    assign is_ls = (op == OP_LW) || (op == OP_SW);

    always_comb begin
        alu_op_sel = 3'b000;
        case (op)
            OP_SUB:        alu_op_sel = 3'b001;
            OP_AND:        alu_op_sel = 3'b100;
            OP_OR, OP_ORI: alu_op_sel = 3'b101;
            OP_SLT:        alu_op_sel = 3'b110;
            default:       alu_op_sel = 3'b000;
        endcase
    end

    always_comb begin
        state_d   = S_IF;
        halted_d  = halted_q;
        PCWre     = 1'b0;
        PCsrc     = 2'b00;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 2'b10;
        WrRegDSrc = 1'b1;
        ALUSrcB   = 1'b0;
        ALUOp     = 3'b000;
        ExtSel    = 1'b1;
        DataMemRW = 1'b0;
        DBDataSrc = 1'b0;
        // Once halted, everything stays at defaults and the FSM parks in S_IF.
        if (!halted_q) begin
            case (state_q)
                S_IF: begin
                    IRWre   = 1'b1;
                    state_d = S_ID;
                end
                S_ID: begin
                    if (is_r || is_i) begin
                        state_d = S_EXE_AL;
                    end else if (is_ls) begin
                        state_d = S_EXE_LS;
                    end else if (op == OP_BEQ) begin
                        state_d = S_EXE_BR;
                    end else begin
                        case (op)
                            OP_J: begin
                                PCWre = 1'b1;
                                PCsrc = 2'b11;
                            end
                            OP_JR: begin
                                PCWre = 1'b1;
                                PCsrc = 2'b10;
                            end
                            OP_JAL: begin
                                PCWre     = 1'b1;
                                PCsrc     = 2'b11;
                                RegWre    = 1'b1;
                                RegDst    = 2'b00;
                                WrRegDSrc = 1'b0;
                            end
                            OP_HALT: halted_d = 1'b1;
                            default: PCWre = 1'b1;
                        endcase
                    end
                end
                S_EXE_AL, S_WB_AL: begin
                    ALUOp   = alu_op_sel;
                    ALUSrcB = is_i;
                    ExtSel  = (op != OP_ORI);
                    if (state_q == S_EXE_AL) begin
                        state_d = S_WB_AL;
                    end else begin
                        RegWre = 1'b1;
                        RegDst = is_r ? 2'b10 : 2'b01;
                        PCWre  = 1'b1;
                    end
                end
                S_EXE_BR: begin
                    ALUOp = 3'b001;
                    PCWre = 1'b1;
                    PCsrc = zero ? 2'b01 : 2'b00;
                end
                S_EXE_LS: begin
                    ALUSrcB = 1'b1;
                    state_d = S_MEM;
                end
                S_MEM: begin
                    if (op == OP_LW) begin
                        state_d = S_WB_LD;
                    end else begin
                        DataMemRW = (op == OP_SW);
                        PCWre     = 1'b1;
                    end
                end
                S_WB_LD: begin
                    RegWre    = 1'b1;
                    RegDst    = 2'b01;
                    DBDataSrc = 1'b1;
                    PCWre     = 1'b1;
                end
                default: state_d = S_IF;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IF;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    assign state  = state_q;
    assign halted = halted_q;
endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: per-instruction expected output vectors are queued
// when an opcode is applied and popped/compared once per cycle.
module tb_mc_control_unit;
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] OP_ILL  = 6'b101010;

    typedef struct packed {
        logic [2:0] st;
        logic       hl;
        logic       pcwre;
        logic [1:0] pcsrc;
        logic       irwre;
        logic       regwre;
        logic [1:0] regdst;
        logic       wrsrc;
        logic       alusrcb;
        logic [2:0] aluop;
        logic       extsel;
        logic       memrw;
        logic       dbsrc;
    } vec_t;

    logic       CLK;
    logic       RST;
    logic [5:0] op;
    logic       zero;
    logic [2:0] state;
    logic       halted, PCWre, IRWre, RegWre, WrRegDSrc, ALUSrcB, ExtSel, DataMemRW, DBDataSrc;
    logic [1:0] PCsrc, RegDst;
    logic [2:0] ALUOp;

    int   errors = 0;
    int   checks = 0;
    vec_t sb[$];

    mc_control_unit dut (
        .CLK(CLK), .RST(RST), .op(op), .zero(zero),
        .state(state), .halted(halted), .PCWre(PCWre), .PCsrc(PCsrc),
        .IRWre(IRWre), .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel),
        .DataMemRW(DataMemRW), .DBDataSrc(DBDataSrc)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic vec_t dflt(input logic [2:0] st, input logic hl);
        vec_t v;
        v        = '0;
        v.st     = st;
        v.hl     = hl;
        v.regdst = 2'b10;
        v.wrsrc  = 1'b1;
        v.extsel = 1'b1;
        return v;
    endfunction

    function automatic vec_t observe();
        vec_t v;
        v.st = state;       v.hl = halted;       v.pcwre = PCWre;     v.pcsrc = PCsrc;
        v.irwre = IRWre;    v.regwre = RegWre;   v.regdst = RegDst;   v.wrsrc = WrRegDSrc;
        v.alusrcb = ALUSrcB; v.aluop = ALUOp;    v.extsel = ExtSel;
        v.memrw = DataMemRW; v.dbsrc = DBDataSrc;
        return v;
    endfunction

    // Expected per-cycle outputs for one complete instruction, from the opcode table.
    task automatic push_instr(input logic [5:0] o, input logic z);
        vec_t v;
        v = dflt(3'b000, 1'b0);
        v.irwre = 1'b1;
        sb.push_back(v);
        v = dflt(3'b001, 1'b0);
        case (o)
            OP_J:  begin v.pcwre = 1'b1; v.pcsrc = 2'b11; sb.push_back(v); end
            OP_JR: begin v.pcwre = 1'b1; v.pcsrc = 2'b10; sb.push_back(v); end
            OP_JAL: begin
                v.pcwre = 1'b1; v.pcsrc = 2'b11;
                v.regwre = 1'b1; v.regdst = 2'b00; v.wrsrc = 1'b0;
                sb.push_back(v);
            end
            OP_HALT: sb.push_back(v);
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI, OP_ORI: begin
                sb.push_back(v);
                v = dflt(3'b110, 1'b0);
                case (o)
                    OP_SUB:        v.aluop = 3'b001;
                    OP_AND:        v.aluop = 3'b100;
                    OP_OR, OP_ORI: v.aluop = 3'b101;
                    OP_SLT:        v.aluop = 3'b110;
                    default:       v.aluop = 3'b000;
                endcase
                v.alusrcb = (o == OP_ADDI) || (o == OP_ORI);
                v.extsel  = (o != OP_ORI);
                sb.push_back(v);
                v.st     = 3'b111;
                v.regwre = 1'b1;
                v.regdst = ((o == OP_ADDI) || (o == OP_ORI)) ? 2'b01 : 2'b10;
                v.pcwre  = 1'b1;
                sb.push_back(v);
            end
            OP_LW, OP_SW: begin
                sb.push_back(v);
                v = dflt(3'b010, 1'b0);
                v.alusrcb = 1'b1;
                sb.push_back(v);
                v = dflt(3'b011, 1'b0);
                if (o == OP_SW) begin
                    v.memrw = 1'b1; v.pcwre = 1'b1;
                    sb.push_back(v);
                end else begin
                    sb.push_back(v);
                    v = dflt(3'b100, 1'b0);
                    v.regwre = 1'b1; v.regdst = 2'b01; v.dbsrc = 1'b1; v.pcwre = 1'b1;
                    sb.push_back(v);
                end
            end
            OP_BEQ: begin
                sb.push_back(v);
                v = dflt(3'b101, 1'b0);
                v.aluop = 3'b001; v.pcwre = 1'b1;
                v.pcsrc = z ? 2'b01 : 2'b00;
                sb.push_back(v);
            end
            default: begin v.pcwre = 1'b1; sb.push_back(v); end
        endcase
    endtask

    task automatic test_reset();
        vec_t exp, obs;
        RST = 1'b0; op = OP_ADD; zero = 1'b0;
        #1;
        exp = dflt(3'b000, 1'b0);
        exp.irwre = 1'b1;
        obs = observe();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset: got %h expected %h", obs, exp);
        end
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_add();
        vec_t exp, obs;
        int   cyc = 0;
        push_instr(OP_ADD, 1'b0);
        op = OP_ADD;
        while (sb.size() > 0) begin
            #1;
            exp = sb.pop_front(); obs = observe(); checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL add cyc%0d: got %h expected %h", cyc, obs, exp);
            end
            cyc++;
            @(negedge CLK);
        end
        $display("add: %0d cycles checked", cyc);
    endtask

    task automatic test_alu_ops();
        logic [5:0] ops [6] = '{OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI, OP_ORI};
        vec_t exp, obs;
        for (int k = 0; k < 6; k++) begin
            int cyc = 0;
            push_instr(ops[k], 1'b0);
            op = ops[k];
            while (sb.size() > 0) begin
                zero = 1'($urandom_range(0, 1));
                #1;
                exp = sb.pop_front(); obs = observe(); checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL alu op=%b cyc%0d: got %h expected %h", ops[k], cyc, obs, exp);
                end
                cyc++;
                @(negedge CLK);
            end
            $display("alu op=%b: %0d cycles checked", ops[k], cyc);
        end
        zero = 1'b0;
    endtask

    task automatic test_load_store();
        logic [5:0] ops [2] = '{OP_LW, OP_SW};
        vec_t exp, obs;
        for (int k = 0; k < 2; k++) begin
            int cyc = 0;
            push_instr(ops[k], 1'b0);
            op = ops[k];
            while (sb.size() > 0) begin
                #1;
                exp = sb.pop_front(); obs = observe(); checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL ldst op=%b cyc%0d: got %h expected %h", ops[k], cyc, obs, exp);
                end
                cyc++;
                @(negedge CLK);
            end
            $display("ldst op=%b: %0d cycles checked", ops[k], cyc);
        end
    endtask

    task automatic test_branch();
        vec_t exp, obs;
        for (int k = 0; k < 2; k++) begin
            int   cyc = 0;
            logic z;
            z = (k == 0);
            push_instr(OP_BEQ, z);
            op = OP_BEQ; zero = z;
            while (sb.size() > 0) begin
                #1;
                exp = sb.pop_front(); obs = observe(); checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL beq zero=%0b cyc%0d: got %h expected %h", z, cyc, obs, exp);
                end
                cyc++;
                @(negedge CLK);
            end
            $display("beq zero=%0b: %0d cycles checked", z, cyc);
        end
        zero = 1'b0;
    endtask

    task automatic test_jumps();
        logic [5:0] ops [3] = '{OP_J, OP_JR, OP_JAL};
        vec_t exp, obs;
        for (int k = 0; k < 3; k++) begin
            int cyc = 0;
            push_instr(ops[k], 1'b0);
            op = ops[k];
            while (sb.size() > 0) begin
                #1;
                exp = sb.pop_front(); obs = observe(); checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL jump op=%b cyc%0d: got %h expected %h", ops[k], cyc, obs, exp);
                end
                cyc++;
                @(negedge CLK);
            end
            $display("jump op=%b: %0d cycles checked", ops[k], cyc);
        end
    endtask

    task automatic test_halt();
        vec_t exp, obs;
        int   cyc = 0;
        push_instr(OP_HALT, 1'b0);
        for (int k = 0; k < 10; k++) sb.push_back(dflt(3'b000, 1'b1));
        op = OP_HALT;
        while (sb.size() > 0) begin
            #1;
            exp = sb.pop_front(); obs = observe(); checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL halt cyc%0d: got %h expected %h", cyc, obs, exp);
            end
            cyc++;
            @(negedge CLK);
        end
        $display("halt: %0d cycles checked", cyc);
        RST = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || state !== 3'b000) begin
            errors++;
            $display("FAIL halt_clear: got halted=%b state=%b expected 0/000", halted, state);
        end
        @(negedge CLK);
        RST = 1'b1;
        cyc = 0;
        push_instr(OP_ADD, 1'b0);
        op = OP_ADD;
        while (sb.size() > 0) begin
            #1;
            exp = sb.pop_front(); obs = observe(); checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL add_after_halt cyc%0d: got %h expected %h", cyc, obs, exp);
            end
            cyc++;
            @(negedge CLK);
        end
        $display("add after halt: %0d cycles checked", cyc);
    endtask

    task automatic test_reset_mid();
        vec_t exp, obs;
        int   cyc = 0;
        push_instr(OP_SW, 1'b0);
        op = OP_SW;
        while (sb.size() > 0) begin
            #1;
            exp = sb.pop_front(); obs = observe(); checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL sw_mid cyc%0d: got %h expected %h", cyc, obs, exp);
            end
            cyc++;
            if (sb.size() > 0) @(negedge CLK);
        end
        // Now inside S_MEM, before its closing edge: drop reset asynchronously.
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if (state !== 3'b000 || DataMemRW !== 1'b0 || PCWre !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got state=%b memrw=%b pcwre=%b expected 000/0/0",
                     state, DataMemRW, PCWre);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (state !== 3'b000 || PCWre !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got state=%b pcwre=%b expected 000/0", state, PCWre);
        end
        @(negedge CLK);
        RST = 1'b1;
        cyc = 0;
        push_instr(OP_ILL, 1'b0);
        op = OP_ILL;
        while (sb.size() > 0) begin
            #1;
            exp = sb.pop_front(); obs = observe(); checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL illegal cyc%0d: got %h expected %h", cyc, obs, exp);
            end
            cyc++;
            @(negedge CLK);
        end
        #1;
        checks++;
        if (state !== 3'b000) begin
            errors++;
            $display("FAIL illegal_return: got state=%b expected 000", state);
        end
        $display("illegal: %0d cycles checked", cyc);
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_load_store();
        test_branch();
        test_jumps();
        test_halt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle CPU control FSM. Decodes the IR opcode and sequences each instruction through IF/ID/EXE/MEM/WB.
- Drives every datapath enable and mux select.
- Directly upstream of the next-PC selector: produces PCsrc, which selects the next-PC source, and PCWre, which commits the selected value into the PC register.

Parameters:
- S_IF, 3'b000, instruction fetch state code
- S_ID, 3'b001, decode / register read
- S_EXE_AL, 3'b110, ALU execute for R-type and I-type arithmetic
- S_WB_AL, 3'b111, ALU write-back
- S_EXE_BR, 3'b101, branch compare
- S_EXE_LS, 3'b010, load/store address calculation
- S_MEM, 3'b011, data memory access
- S_WB_LD, 3'b100, load write-back
- S_HALT: no separate code; reuses 3'b000 with halt_flag=1

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset
- op  in  6  opcode from the IR
- zero  in  1  ALU zero flag, valid in S_EXE_BR
- state  out  3  current state code, for debug and the IR/ALU pipeline registers
- halted  out  1  high once a halt has been decoded
- PCWre  out  1  PC register write enable
- PCsrc  out  2  00 = PC+4, 01 = PC+4+(imm<<2), 10 = rs register, 11 = jump target
- IRWre  out  1  IR load enable
- RegWre  out  1  register file write enable
- RegDst  out  2  00 = $31, 01 = rt, 10 = rd
- WrRegDSrc  out  1  0 = PC+4 (jal), 1 = ALU/memory result
- ALUSrcB  out  1  0 = rt, 1 = extended immediate
- ALUOp  out  3  000 add, 001 sub, 100 and, 101 or, 110 slt
- ExtSel  out  1  0 = zero-extend, 1 = sign-extend
- DataMemRW  out  1  1 = write
- DBDataSrc  out  1  0 = ALU result, 1 = memory data

Behaviour:
- Opcodes:
  - add 000000, sub 000001, and 010001, or 010010, slt 100110 (R-type)
  - addi 000010, ori 010000
  - sw 110000, lw 110001
  - beq 110100
  - j 111000, jr 111001, jal 111010
  - halt 111111
  - Any other opcode is an illegal NOP.
- Only state and halted are registered. All other outputs are combinational functions of (state, op, zero, halted).
- Reset (RST=0, asynchronous): state=S_IF, halted=0. Reset may arrive mid-instruction; the instruction in progress is abandoned and nothing further is written.
- Output defaults: all enables 0, PCsrc=00, RegDst=10, WrRegDSrc=1, ALUSrcB=0, ALUOp=000, ExtSel=1, DBDataSrc=0.
- S_IF: IRWre=1 (when halted=0). Next state S_ID.
- S_ID, next-state rules:
  - R-type and I-type arithmetic -> S_EXE_AL
  - lw/sw -> S_EXE_LS
  - beq -> S_EXE_BR
  - j/jr/jal -> S_IF, with PCWre=1 and PCsrc=11/10/11 respectively
  - jal additionally asserts RegWre=1, RegDst=00, WrRegDSrc=0
  - halt -> halted<=1, stays S_IF, PCWre=0
  - illegal -> S_IF with PCWre=1, PCsrc=00
- S_EXE_AL: ALUOp per opcode. addi uses 000 and ori uses 101. ALUSrcB=1 for addi/ori. ExtSel=0 for ori. Next state S_WB_AL.
- S_WB_AL: RegWre=1, RegDst=10 for R-type and 01 for I-type, PCWre=1, PCsrc=00. ALU controls held from S_EXE_AL. Next state S_IF.
- S_EXE_BR: ALUOp=001, PCWre=1, PCsrc = zero ? 01 : 00. Next state S_IF.
- S_EXE_LS: ALUSrcB=1, ALUOp=000, ExtSel=1. Next state S_MEM.
- S_MEM:
  - sw: DataMemRW=1, PCWre=1, next S_IF.
  - lw: DataMemRW=0, next S_WB_LD.
- S_WB_LD: RegWre=1, RegDst=01, DBDataSrc=1, PCWre=1, PCsrc=00. Next state S_IF.
- Cycle counts per instruction:
  - j/jr/jal: 2
  - beq: 3
  - R-type, I-type, sw: 4
  - lw: 5
- PCWre is asserted in exactly one cycle per instruction: the last one.
- Halted:
  - While halted=1 the FSM holds in S_IF, and IRWre, PCWre, RegWre and DataMemRW are all 0.
  - Only RST clears halted.
- Unreachable state codes return to S_IF on the next edge with all enables 0.

Test Plan:
- Reset then add (op=000000): state sequence 000 -> 001 -> 110 -> 111 -> 000. IRWre=1 only in the first cycle. RegWre=1, RegDst=10 and PCWre=1, PCsrc=00 only in the fourth cycle.
- lw (110001), then sw (110000): lw is 5 cycles with DBDataSrc=1 and RegWre=1 in S_WB_LD. sw is 4 cycles with DataMemRW=1 and PCWre=1 in S_MEM, and RegWre never asserts.
- beq with zero=1, then zero=0: 3 cycles each. In S_EXE_BR, PCsrc=01 for the first and 00 for the second, with PCWre=1 in both.
- j, jr, jal: each is 2 cycles. In S_ID, PCsrc is 11, 10 and 11 respectively, with PCWre=1. jal also drives RegWre=1, RegDst=00, WrRegDSrc=0.
- halt (111111): halted=1 after S_ID. For 10 further cycles state=000 and all enables stay 0. Asserting RST=0 clears halted, and the next op=000000 executes normally.
- Reset mid-instruction: RST dropped asynchronously in S_MEM of an sw. state becomes 000 immediately, DataMemRW=0, and there is no PCWre pulse. Also apply illegal op=101010: 2 cycles, PCWre=1, PCsrc=00.
